// File: rtl/mips_ir_pkg.sv
// Shared types and constants for the MIPS instruction fetch register: FSM state,
// opcode/funct encodings and instruction field bit positions.
package mips_ir_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFill  = 2'd1,
        StValid = 2'd2
    } ir_state_e;

    localparam logic [5:0] OpRType = 6'b000000;
    localparam logic [5:0] OpLb    = 6'b100000;
    localparam logic [5:0] OpSb    = 6'b101000;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpJ     = 6'b000010;

    localparam logic [5:0] FnAdd = 6'b100000;
    localparam logic [5:0] FnSub = 6'b100010;
    localparam logic [5:0] FnAnd = 6'b100100;
    localparam logic [5:0] FnOr  = 6'b100101;
    localparam logic [5:0] FnSlt = 6'b101010;

    localparam int unsigned BitOp1 = 27;
    localparam int unsigned BitOp2 = 28;
    localparam int unsigned BitOp3 = 29;
    localparam int unsigned BitOp5 = 31;
    localparam int unsigned BitF0  = 0;
    localparam int unsigned BitF1  = 1;
    localparam int unsigned BitF2  = 2;
    localparam int unsigned BitF3  = 3;

    localparam int unsigned OpMsb = 31;
    localparam int unsigned OpLsb = 26;
    localparam int unsigned RsMsb = 25;
    localparam int unsigned RsLsb = 21;
    localparam int unsigned RtMsb = 20;
    localparam int unsigned RtLsb = 16;
    localparam int unsigned RdMsb = 15;
    localparam int unsigned RdLsb = 11;
    localparam int unsigned FnMsb = 5;
    localparam int unsigned FnLsb = 0;
    localparam int unsigned ImmMsb = 15;
    localparam int unsigned ImmLsb = 0;

    function automatic logic is_illegal_op(input logic [31:0] ir);
        logic [5:0] op;
        logic [5:0] fn;
        logic       illegal;
        op      = ir[OpMsb:OpLsb];
        fn      = ir[FnMsb:FnLsb];
        illegal = 1'b1;
        case (op)
            OpRType: begin
                case (fn)
                    FnAdd, FnSub, FnAnd, FnOr, FnSlt: illegal = 1'b0;
                    default:                          illegal = 1'b1;
                endcase
            end
            OpLb, OpSb, OpAddi, OpBeq, OpJ: illegal = 1'b0;
            default:                        illegal = 1'b1;
        endcase
        return illegal;
    endfunction

endpackage

// File: rtl/ir_byte_slot.sv
// One byte lane of the instruction register: enable flop with synchronous
// active-low clear.
module ir_byte_slot #(
    parameter int unsigned DataW = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [DataW-1:0] d_i,
    output logic [DataW-1:0] q_o
);

    logic [DataW-1:0] byte_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            byte_q <= '0;
        end else if (en_i) begin
            byte_q <= d_i;
        end
    end

    assign q_o = byte_q;

endmodule

// File: rtl/instr_fetch_register.sv
// Assembles a 32-bit MIPS instruction from byte-wide memory reads and drives decode fields.
// Optional IllegalOp output is built when IFR_ILLEGAL_OP_EN is defined.
module instr_fetch_register
    import mips_ir_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned IR_BYTES = 4
) (
    input  logic              Fclk,
    input  logic              Reset,
    input  logic [DATA_W-1:0] MemData,
    input  logic              MemValid,
    input  logic              IRWr0,
    input  logic              IRWr1,
    input  logic              FetchStart,
    output logic              ByteReq,
    output logic [1:0]        ByteIdx,
    output logic              IR_Valid,
`ifdef IFR_ILLEGAL_OP_EN
    output logic              IllegalOp,
`endif
    output logic              OP1,
    output logic              OP2,
    output logic              OP3,
    output logic              OP5,
    output logic              F0,
    output logic              F1,
    output logic              F2,
    output logic              F3,
    output logic [4:0]        Rs,
    output logic [4:0]        Rt,
    output logic [4:0]        Rd,
    output logic [15:0]       Imm16
);

    localparam int unsigned IrW     = DATA_W * IR_BYTES;
    localparam logic [1:0]  LastIdx = 2'(IR_BYTES - 1);
    localparam logic [1:0]  HalfIdx = 2'(IR_BYTES / 2);

    ir_state_e        state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic             byte_req_q, byte_req_d;
    logic             ir_valid_q, ir_valid_d;
    logic             half_strobe;
    logic             wr_en;
    logic [IrW-1:0]   ir;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        byte_req_d = byte_req_q;
        ir_valid_d = 1'b0;
        wr_en      = 1'b0;
        // Lower half of the instruction is strobed by IRWr0, upper half by IRWr1.
        half_strobe = (idx_q >= HalfIdx) ? IRWr1 : IRWr0;

        unique case (state_q)
            StIdle: begin
                byte_req_d = 1'b0;
                if (FetchStart) begin
                    state_d    = StFill;
                    idx_d      = '0;
                    byte_req_d = 1'b1;
                end
            end
            StFill: begin
                if (FetchStart) begin
                    idx_d      = '0;
                    byte_req_d = 1'b1;
                end else if (MemValid && half_strobe) begin
                    wr_en = 1'b1;
                    if (idx_q == LastIdx) begin
                        state_d    = StValid;
                        byte_req_d = 1'b0;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            StValid: begin
                if (FetchStart) begin
                    state_d    = StFill;
                    idx_d      = '0;
                    byte_req_d = 1'b1;
                end else begin
                    ir_valid_d = 1'b1;
                end
            end
            default: begin
                state_d    = StIdle;
                idx_d      = '0;
                byte_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Fclk) begin
        if (!Reset) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            byte_req_q <= 1'b0;
            ir_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            byte_req_q <= byte_req_d;
            ir_valid_q <= ir_valid_d;
        end
    end

    for (genvar k = 0; k < IR_BYTES; k++) begin : g_slot
        ir_byte_slot #(
            .DataW(DATA_W)
        ) u_slot (
            .clk_i (Fclk),
            .rst_ni(Reset),
            .en_i  (wr_en && (idx_q == 2'(k))),
            .d_i   (MemData),
            .q_o   (ir[k*DATA_W +: DATA_W])
        );
    end

`ifdef IFR_ILLEGAL_OP_EN
    logic illegal_q, illegal_d;

    // Evaluated on the same condition that raises IR_Valid, so both rise together.
    assign illegal_d = ir_valid_d ? is_illegal_op(ir[31:0]) : 1'b0;

    always_ff @(posedge Fclk) begin
        if (!Reset) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end

    assign IllegalOp = illegal_q;
`endif

    logic unused_ir_bits;
    assign unused_ir_bits = ^{ir[30], ir[26]};

    assign ByteReq  = byte_req_q;
    assign ByteIdx  = idx_q;
    assign IR_Valid = ir_valid_q;

    assign OP1   = ir[BitOp1];
    assign OP2   = ir[BitOp2];
    assign OP3   = ir[BitOp3];
    assign OP5   = ir[BitOp5];
    assign F0    = ir[BitF0];
    assign F1    = ir[BitF1];
    assign F2    = ir[BitF2];
    assign F3    = ir[BitF3];
    assign Rs    = ir[RsMsb:RsLsb];
    assign Rt    = ir[RtMsb:RtLsb];
    assign Rd    = ir[RdMsb:RdLsb];
    assign Imm16 = ir[ImmMsb:ImmLsb];

endmodule

// File: tb/tb_instr_fetch_register.sv
// Directed self-checking bench for instr_fetch_register.
module tb_instr_fetch_register;

    logic        Fclk;
    logic        Reset;
    logic [7:0]  MemData;
    logic        MemValid;
    logic        IRWr0;
    logic        IRWr1;
    logic        FetchStart;
    logic        ByteReq;
    logic [1:0]  ByteIdx;
    logic        IR_Valid;
`ifdef IFR_ILLEGAL_OP_EN
    logic        IllegalOp;
`endif
    logic        OP1, OP2, OP3, OP5;
    logic        F0, F1, F2, F3;
    logic [4:0]  Rs, Rt, Rd;
    logic [15:0] Imm16;

    int checks;
    int failures;

    instr_fetch_register #(
        .DATA_W  (8),
        .IR_BYTES(4)
    ) dut (
        .Fclk      (Fclk),
        .Reset     (Reset),
        .MemData   (MemData),
        .MemValid  (MemValid),
        .IRWr0     (IRWr0),
        .IRWr1     (IRWr1),
        .FetchStart(FetchStart),
        .ByteReq   (ByteReq),
        .ByteIdx   (ByteIdx),
        .IR_Valid  (IR_Valid),
`ifdef IFR_ILLEGAL_OP_EN
        .IllegalOp (IllegalOp),
`endif
        .OP1       (OP1),
        .OP2       (OP2),
        .OP3       (OP3),
        .OP5       (OP5),
        .F0        (F0),
        .F1        (F1),
        .F2        (F2),
        .F3        (F3),
        .Rs        (Rs),
        .Rt        (Rt),
        .Rd        (Rd),
        .Imm16     (Imm16)
    );

    initial Fclk = 1'b0;
    always #5 Fclk = ~Fclk;

    task automatic step();
        @(posedge Fclk);
        #1;
    endtask

    task automatic put_byte(input logic [7:0] b, input logic w0, input logic w1);
        MemData  = b;
        MemValid = 1'b1;
        IRWr0    = w0;
        IRWr1    = w1;
        step();
        MemValid = 1'b0;
        IRWr0    = 1'b0;
        IRWr1    = 1'b0;
    endtask

    task automatic fetch_start();
        FetchStart = 1'b1;
        step();
        FetchStart = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        step();
        step();
        checks++;
        if ({ByteReq, IR_Valid, ByteIdx} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=0000", {ByteReq, IR_Valid, ByteIdx});
        end
        checks++;
        if ({Imm16, Rs, Rt} !== 26'd0) begin
            failures++;
            $display("FAIL reset_fields got=%h exp=0", {Imm16, Rs, Rt});
        end
        Reset = 1'b1;
        step();
        // A strobed byte in IDLE must not be written.
        put_byte(8'h5A, 1'b1, 1'b0);
        checks++;
        if ({ByteIdx, Imm16} !== 18'd0) begin
            failures++;
            $display("FAIL idle_no_write got=%h exp=0", {ByteIdx, Imm16});
        end
        fetch_start();
        checks++;
        if ({ByteReq, ByteIdx, IR_Valid} !== 4'b1000) begin
            failures++;
            $display("FAIL start_fill got=%b exp=1000", {ByteReq, ByteIdx, IR_Valid});
        end
        put_byte(8'h5A, 1'b1, 1'b0);
        put_byte(8'hA5, 1'b1, 1'b0);
        checks++;
        if (Imm16 !== 16'hA55A || ByteIdx !== 2'd2) begin
            failures++;
            $display("FAIL partial_fill got=%h/%0d exp=a55a/2", Imm16, ByteIdx);
        end
        Reset = 1'b0;
        step();
        checks++;
        if ({Imm16, ByteIdx, ByteReq, IR_Valid} !== 20'd0) begin
            failures++;
            $display("FAIL reset_midfill got=%h exp=0", {Imm16, ByteIdx, ByteReq, IR_Valid});
        end
        step();
        Reset = 1'b1;
        step();
    endtask

    task automatic test_add_load();
        fetch_start();
        put_byte(8'h20, 1'b1, 1'b0);
        checks++;
        if (ByteIdx !== 2'd1) begin
            failures++;
            $display("FAIL add_idx1 got=%0d exp=1", ByteIdx);
        end
        put_byte(8'h10, 1'b1, 1'b0);
        put_byte(8'h22, 1'b0, 1'b1);
        checks++;
        if (ByteIdx !== 2'd3 || ByteReq !== 1'b1) begin
            failures++;
            $display("FAIL add_idx3 got=%0d/%b exp=3/1", ByteIdx, ByteReq);
        end
        put_byte(8'h01, 1'b0, 1'b1);
        checks++;
        if (ByteReq !== 1'b0 || IR_Valid !== 1'b0) begin
            failures++;
            $display("FAIL add_final_edge got=%b%b exp=00", ByteReq, IR_Valid);
        end
        step();
        checks++;
        if (IR_Valid !== 1'b1) begin
            failures++;
            $display("FAIL add_valid got=%b exp=1", IR_Valid);
        end
        checks++;
        if ({OP5, OP3, OP2, OP1, F3, F2, F1, F0} !== 8'h00) begin
            failures++;
            $display("FAIL add_opfn got=%b exp=00000000", {OP5, OP3, OP2, OP1, F3, F2, F1, F0});
        end
        checks++;
        if (Rs !== 5'd9 || Rt !== 5'd2 || Rd !== 5'd2 || Imm16 !== 16'h1020) begin
            failures++;
            $display("FAIL add_regs got=%0d,%0d,%0d,%h exp=9,2,2,1020", Rs, Rt, Rd, Imm16);
        end
`ifdef IFR_ILLEGAL_OP_EN
        checks++;
        if (IllegalOp !== 1'b0) begin
            failures++;
            $display("FAIL add_illegal got=%b exp=0", IllegalOp);
        end
`endif
        step();
        step();
        checks++;
        if (IR_Valid !== 1'b1 || Imm16 !== 16'h1020) begin
            failures++;
            $display("FAIL add_hold got=%b/%h exp=1/1020", IR_Valid, Imm16);
        end
    endtask

    task automatic test_discard();
        fetch_start();
        checks++;
        if (IR_Valid !== 1'b0 || ByteIdx !== 2'd0 || Imm16 !== 16'h1020) begin
            failures++;
            $display("FAIL refetch got=%b/%0d/%h exp=0/0/1020", IR_Valid, ByteIdx, Imm16);
        end
        put_byte(8'hAA, 1'b1, 1'b0);
        put_byte(8'h55, 1'b0, 1'b0);
        checks++;
        if (ByteIdx !== 2'd1 || Imm16 !== 16'h10AA) begin
            failures++;
            $display("FAIL no_strobe got=%0d/%h exp=1/10aa", ByteIdx, Imm16);
        end
        put_byte(8'h66, 1'b0, 1'b1);
        checks++;
        if (ByteIdx !== 2'd1 || Imm16 !== 16'h10AA) begin
            failures++;
            $display("FAIL wrong_half got=%0d/%h exp=1/10aa", ByteIdx, Imm16);
        end
        MemData = 8'h77;
        IRWr0   = 1'b1;
        step();
        IRWr0   = 1'b0;
        checks++;
        if (ByteIdx !== 2'd1 || Imm16 !== 16'h10AA) begin
            failures++;
            $display("FAIL no_valid got=%0d/%h exp=1/10aa", ByteIdx, Imm16);
        end
        put_byte(8'hBB, 1'b1, 1'b0);
        checks++;
        if (ByteIdx !== 2'd2 || Imm16 !== 16'hBBAA) begin
            failures++;
            $display("FAIL discard_resume got=%0d/%h exp=2/bbaa", ByteIdx, Imm16);
        end
    endtask

    task automatic test_abort();
        fetch_start();
        checks++;
        if (ByteIdx !== 2'd0 || IR_Valid !== 1'b0 || ByteReq !== 1'b1 || Imm16 !== 16'hBBAA) begin
            failures++;
            $display("FAIL abort got=%0d/%b/%b/%h exp=0/0/1/bbaa", ByteIdx, IR_Valid, ByteReq,
                     Imm16);
        end
        put_byte(8'h04, 1'b1, 1'b0);
        put_byte(8'h00, 1'b1, 1'b0);
        put_byte(8'h01, 1'b0, 1'b1);
        put_byte(8'h80, 1'b0, 1'b1);
        step();
        checks++;
        if (IR_Valid !== 1'b1 || OP5 !== 1'b1 || {OP3, OP2, OP1} !== 3'b000) begin
            failures++;
            $display("FAIL lb_op got=%b/%b%b%b%b exp=1/1000", IR_Valid, OP5, OP3, OP2, OP1);
        end
        checks++;
        if (Rs !== 5'd0 || Rt !== 5'd1 || Imm16 !== 16'h0004 || {F3, F2, F1, F0} !== 4'b0100)
        begin
            failures++;
            $display("FAIL lb_fields got=%0d,%0d,%h,%b exp=0,1,0004,0100", Rs, Rt, Imm16,
                     {F3, F2, F1, F0});
        end
`ifdef IFR_ILLEGAL_OP_EN
        checks++;
        if (IllegalOp !== 1'b0) begin
            failures++;
            $display("FAIL lb_illegal got=%b exp=0", IllegalOp);
        end
`endif
    endtask

    task automatic test_back_to_back();
        fetch_start();
        put_byte(8'h00, 1'b1, 1'b0);
        put_byte(8'h00, 1'b1, 1'b0);
        put_byte(8'h00, 1'b0, 1'b1);
        // Final byte coincides with FetchStart: the restart wins.
        FetchStart = 1'b1;
        put_byte(8'hFC, 1'b0, 1'b1);
        FetchStart = 1'b0;
        checks++;
        if (ByteIdx !== 2'd0 || ByteReq !== 1'b1 || IR_Valid !== 1'b0) begin
            failures++;
            $display("FAIL coincide_ctrl got=%0d/%b/%b exp=0/1/0", ByteIdx, ByteReq, IR_Valid);
        end
        checks++;
        if ({OP3, OP2, OP1} !== 3'b000 || OP5 !== 1'b1) begin
            failures++;
            $display("FAIL coincide_kept got=%b%b%b%b exp=1000", OP5, OP3, OP2, OP1);
        end
        step();
        checks++;
        if (IR_Valid !== 1'b0 || ByteIdx !== 2'd0) begin
            failures++;
            $display("FAIL coincide_stay got=%b/%0d exp=0/0", IR_Valid, ByteIdx);
        end
        put_byte(8'h00, 1'b1, 1'b0);
        put_byte(8'h00, 1'b1, 1'b0);
        put_byte(8'h00, 1'b0, 1'b1);
        put_byte(8'hFC, 1'b0, 1'b1);
        step();
        checks++;
        if (IR_Valid !== 1'b1 || {OP5, OP3, OP2, OP1} !== 4'b1111 || Imm16 !== 16'h0000) begin
            failures++;
            $display("FAIL fc_load got=%b/%b%b%b%b/%h exp=1/1111/0000", IR_Valid, OP5, OP3, OP2,
                     OP1, Imm16);
        end
`ifdef IFR_ILLEGAL_OP_EN
        checks++;
        if (IllegalOp !== 1'b1) begin
            failures++;
            $display("FAIL fc_illegal got=%b exp=1", IllegalOp);
        end
        fetch_start();
        checks++;
        if (IllegalOp !== 1'b0 || IR_Valid !== 1'b0) begin
            failures++;
            $display("FAIL illegal_clear got=%b/%b exp=0/0", IllegalOp, IR_Valid);
        end
`endif
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        Reset      = 1'b0;
        MemData    = 8'h00;
        MemValid   = 1'b0;
        IRWr0      = 1'b0;
        IRWr1      = 1'b0;
        FetchStart = 1'b0;
        test_reset();
        test_add_load();
        test_discard();
        test_abort();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_fetch_register.md
Name: instr_fetch_register

Overview:
- Upstream neighbour of the multicycle control unit.
- Assembles a 32-bit MIPS instruction from successive 8-bit memory reads, holds it for the rest of the instruction, and drives the opcode/funct bits the control unit decodes (OP1, OP2, OP3, OP5, F0-F3).
- Also drives register-field and immediate outputs to the datapath.
- Byte loading is strobed by the control unit's out_IRWr0/out_IRWr1.

Parameters:
- DATA_W, 8, memory read data width in bits.
- IR_BYTES, 4, bytes per instruction; IR width is DATA_W*IR_BYTES.

Ports:
- Fclk  input  1  clock; single clock domain, all state updates on its rising edge.
- Reset  input  1  synchronous, active-low reset.
- MemData  input  DATA_W  byte returned by memory.
- MemValid  input  1  MemData is valid this cycle.
- IRWr0  input  1  from control unit; load strobe, low half of the instruction (bytes 0-1).
- IRWr1  input  1  from control unit; load strobe, high half of the instruction (bytes 2-3).
- FetchStart  input  1  from control unit (out_fetch); begin assembling a new instruction.
- ByteReq  output  1  request next memory byte.
- ByteIdx  output  2  index of the byte being filled.
- IR_Valid  output  1  all bytes loaded; fields stable.
- OP1, OP2, OP3, OP5  output  1 each  opcode bits IR[27], IR[28], IR[29], IR[31].
- F0, F1, F2, F3  output  1 each  funct bits IR[0]..IR[3].
- Rs, Rt, Rd  output  5 each  IR[25:21], IR[20:16], IR[15:11].
- Imm16  output  16  IR[15:0].

Behaviour:
- Reset (Reset==0 at a clock edge): state IDLE; IR, ByteIdx, ByteReq and IR_Valid cleared to 0; all decode outputs therefore 0. Reset overrides every other input in the same cycle.
- FSM states:
  - IDLE: FetchStart=1 -> FILL, ByteIdx=0, IR_Valid=0, ByteReq=1 from the next cycle.
  - FILL: a byte is written only when MemValid=1 and the strobe matching the current half is high (IRWr0 for idx 0-1, IRWr1 for idx 2-3).
    - Byte k goes to IR[8k+7:8k], little-endian.
    - ByteIdx then increments.
    - Writing byte IR_BYTES-1 -> VALID; ByteReq drops the same edge; IR_Valid=1 the next cycle.
  - VALID: IR and outputs held. FetchStart=1 -> FILL with ByteIdx=0; IR_Valid drops on that edge and the old IR contents stay until overwritten byte by byte.
- MemValid=1 with the wrong-half strobe, or with no strobe: byte discarded, ByteIdx unchanged, no error.
- Strobe high without MemValid: no write.
- FetchStart during FILL restarts at ByteIdx=0 (abort). Partially written bytes are kept but IR_Valid stays 0.
- FetchStart and the final byte write in the same cycle: the restart wins and the final byte is discarded.
- Latency: minimum 4 cycles from the first accepted byte to the final write; IR_Valid is registered, one cycle after the final write.
- Decode outputs are pure wiring from registered IR, with no extra flop. They are meaningful only while IR_Valid=1.
- ByteIdx wraps only through restart and never exceeds IR_BYTES-1.

Optional Feature:
- Macro: IFR_ILLEGAL_OP_EN.
- When defined:
  - Extra output IllegalOp (1 bit), registered and asserted with IR_Valid.
  - IllegalOp=1 when IR[31:26] is not one of R-type 000000, LB 100000, SB 101000, ADDI 001000, BEQ 000100, J 000010.
  - For R-type, funct outside {add 100000, sub 100010, and 100100, or 100101, slt 101010} also sets IllegalOp.
  - IllegalOp clears on reset and on FetchStart.
- When not defined: the port is absent and behaviour is otherwise identical.

Decomposition:
- Shared package mips_ir_pkg:
  - FSM state enum (IDLE, FILL, VALID).
  - Opcode and funct localparams.
  - Bit-position constants for the OP/F/Rs/Rt/Rd fields.
- One sub-module, ir_byte_slot: a DATA_W-wide enable flop with synchronous active-low clear, instantiated IR_BYTES times.

Test Plan:
- Reset low 2 cycles mid-FILL -> IR=0, IR_Valid=0, ByteIdx=0, ByteReq=0 on the first edge after assertion.
- FetchStart, then bytes 0x20,0x10,0x22,0x01 with IRWr0 on bytes 0-1 and IRWr1 on bytes 2-3:
  - IR_Valid=1 one cycle after the 4th write.
  - IR=0x01221020 (add): OP1=OP2=OP3=OP5=0; F3..F0=0000; Rs=9, Rt=2, Rd=2.
- During FILL, MemValid with no strobe, then with the wrong-half strobe -> ByteIdx unchanged, IR unchanged.
- FetchStart asserted at ByteIdx=2 -> ByteIdx=0, IR_Valid=0; a full 4-byte refill then completes normally.
- Final byte write coincident with FetchStart -> byte discarded, state FILL, ByteIdx=0.
- With IFR_ILLEGAL_OP_EN, load 0xFC000000 -> IllegalOp=1 with IR_Valid.
- With IFR_ILLEGAL_OP_EN, load LB 0x80010004 -> IllegalOp=0, OP5=1, OP3=0.
